cricket_score_ctrl: RTL and testbench
=====================================

# cricket_score_ctrl

Scoring engine for the T20 cricket board. Debounces the scorer's two push-buttons and decodes a 3-bit event switch bank. Keeps runs, wickets and legal-ball count for the batting side and sequences two innings plus the chase. Its outputs drive the seven-segment display controller directly: `binaryRuns`, `wickets`, `ball_count`, `inning_over`, `game_over` and `winner`.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive synchronized cycles a button must differ from its debounced state before the state flips (10 ms at 100 MHz).
- `MAX_BALLS`, default 120: legal balls per innings.
- `MAX_WICKETS`, default 10: wickets per innings.
- `clk_fpga`  in  1  100 MHz board clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_event`  in  1  raw "record event" button, asynchronous.
- `btn_next`  in  1  raw "next innings / new match" button, asynchronous.
- `event_code`  in  3  raw switches:
  - 0: dot
  - 1–4: runs
  - 5: six
  - 6: wicket
  - 7: wide
- `binaryRuns`  out  8  current innings runs; saturates at 255.
- `wickets`  out  4  current innings wickets.
- `ball_count`  out  8  legal balls bowled in current innings.
- `target`  out  8  first-innings total. Valid once `team` = 1.
- `team`  out  1  batting side: 0 = first innings, 1 = second.
- `inning_over`  out  1  high in BREAK and DONE.
- `game_over`  out  1  high in DONE.
- `winner`  out  1  0 = team 1, 1 = team 2. Valid when `game_over` = 1 and `tie` = 0.
- `tie`  out  1  high in DONE when scores are level.

## Operation
- **Input conditioning:**
  - Each button passes through a 2-FF synchronizer, then a debounce counter. The counter resets whenever the synchronized value equals the debounced state.
  - A rising edge of the debounced state gives a one-cycle pulse (`ev_p`, `nx_p`).
  - `event_code` passes through a 2-FF synchronizer. It is sampled on the `ev_p` cycle.
- **States:** INN1, BREAK, INN2, DONE. Reset enters INN1.
- **INN1 / INN2 on `ev_p`:**
  - Codes 1–4 and 5 add 1–4 or 6 runs, then `ball_count`+1.
  - Code 0: `ball_count`+1 only.
  - Code 6: `wickets`+1 and `ball_count`+1.
  - Code 7: see Configuration.
  - Runs add with saturation at 255. `wickets` and `ball_count` never exceed their MAX values.
- **INN1 exit:** on the update that makes `ball_count` = `MAX_BALLS` or `wickets` = `MAX_WICKETS`, go to BREAK. `target` is loaded with the updated runs on that same edge.
- **BREAK:**
  - The first-innings counters stay frozen on the outputs.
  - `nx_p` clears runs, wickets and balls, sets `team` = 1 and goes to INN2.
- **INN2 exit, evaluated on the updated values:**
  - runs > `target`: DONE, `winner` = 1. This check takes priority.
  - Else, balls = `MAX_BALLS` or wickets = `MAX_WICKETS`: DONE. `winner` = 0 if runs < `target`. `tie` = 1 and `winner` = 0 if runs = `target`.
- **DONE:**
  - Counters frozen.
  - `nx_p` clears every counter, `target`, `team`, `winner` and `tie`, then goes to INN1.
- **Ignored inputs:** `ev_p` is ignored in BREAK and DONE. `nx_p` is ignored in INN1 and INN2.
- **Reset mid-operation:** `rst` aborts any state, including mid-debounce. The debounce counters and debounced states clear; a button held through reset must be released and pressed again.

## Timing
- **Reset values:** all outputs 0. State INN1. Debounced states 0.
- **Button latency:**
  - A raw press held stable produces `ev_p`/`nx_p` exactly 2 + `DEBOUNCE_CYCLES` + 1 cycles after the first high sample.
  - Counters and flags update on the clock edge at the end of the pulse cycle, visible one cycle after the pulse.
  - Exactly one update per press. Release generates nothing.
- **State-change flags:** state transitions and `inning_over`/`game_over`/`winner`/`tie` change on the same edge as the counter update that causes them.
- **Glitches:** a glitch shorter than `DEBOUNCE_CYCLES` produces no pulse.
- **Input stability:** `event_code` must be stable for 3 cycles before the pulse. Earlier changes are don't-care.

## Configuration
- **`CRICKET_EXTRAS_EN`:**
  - Defined: code 7 (wide) adds 1 run and does not advance `ball_count`. In INN2 it can end the match by passing `target`.
  - Undefined: code 7 is a no-op; no counter changes.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `MAX_BALLS`=6, `MAX_WICKETS`=2.
- **Reset and debounce:** after reset, apply a 3-cycle glitch on `btn_event` with code 4. Then hold the button for 10 cycles.
  - After the glitch: outputs all 0.
  - After the hold: `binaryRuns`=4 and `ball_count`=1 exactly 8 cycles after the press began.
- **First innings by balls:** six events with codes 5,1,0,6,2,3.
  - Required: `binaryRuns`=12, `wickets`=1, `ball_count`=6, `inning_over`=1, `target`=12.
  - A further `btn_event` changes nothing.
- **Chase won:** `btn_next`, then codes 6,5,5 (runs 12, equal to `target`), then code 1.
  - Required: `team`=1, then `game_over`=1, `winner`=1, `tie`=0 with `ball_count`=4.
- **Tie then restart:** `target`=12 and a second innings ending with runs 12 at `wickets`=2.
  - Required: `tie`=1, `winner`=0.
  - Then `btn_next`: all outputs 0, state INN1.
- **Extras:**
  - With `CRICKET_EXTRAS_EN`: code 7 gives runs +1, balls unchanged.
  - Without it: no change.
  - Also assert `rst` mid-debounce: no pulse follows.

Source files
------------

// File: rtl/cricket_score_ctrl.sv
// cricket_score_ctrl: T20 scoring engine (button debounce, event decode, two innings and chase).
// Optional feature macro CRICKET_EXTRAS_EN: when defined, code 7 (wide) scores one run without a legal ball.

// cricket_debounce: 2-FF synchronizer, debounce counter and one-cycle rising-edge pulse
module cricket_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_fpga,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1;
    logic s2;
    logic db;
    logic db_q;
    logic arm;
    logic [CW-1:0] cnt;
    // Synchronizer is not reset so a button held through reset keeps reading high
    always_ff @(posedge clk_fpga) begin
        s1 <= btn;
        s2 <= s1;
    end
    // Debounce counter, re-arm after release, registered rising-edge pulse
    always_ff @(posedge clk_fpga) begin
        if (rst) begin
            cnt   <= '0;
            db    <= 1'b0;
            db_q  <= 1'b0;
            arm   <= 1'b0;
            pulse <= 1'b0;
        end else begin
            cnt   <= (s2 == db || cnt == LAST) ? '0 : cnt + 1'b1;
            db    <= (s2 != db && cnt == LAST) ? s2 : db;
            db_q  <= db;
            arm   <= arm | ~s2;
            pulse <= db & ~db_q & arm;
        end
    end
endmodule

module cricket_score_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MAX_BALLS       = 120,
    parameter int MAX_WICKETS     = 10
) (
    input  logic       clk_fpga,
    input  logic       rst,
    input  logic       btn_event,
    input  logic       btn_next,
    input  logic [2:0] event_code,
    output logic [7:0] binaryRuns,
    output logic [3:0] wickets,
    output logic [7:0] ball_count,
    output logic [7:0] target,
    output logic       team,
    output logic       inning_over,
    output logic       game_over,
    output logic       winner,
    output logic       tie
);
    localparam logic [7:0] MB = 8'(MAX_BALLS);
    localparam logic [3:0] MW = 4'(MAX_WICKETS);

    typedef enum logic [1:0] {INN1, BREAK, INN2, DONE} state_t;
    state_t state;
    state_t state_nx;

    logic       ev_p;
    logic       nx_p;
    logic [2:0] ec_s1;
    logic [2:0] ec_s2;
    logic       legal;
    logic       is_wkt;
    logic       scores;
    logic       apply;
    logic       end_inn;
    logic       chase_won;
    logic [2:0] add;
    logic [8:0] run_sum;
    logic [7:0] runs_n;
    logic [7:0] balls_n;
    logic [3:0] wkts_n;

    cricket_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_event (
        .clk_fpga(clk_fpga), .rst(rst), .btn(btn_event), .pulse(ev_p)
    );
    cricket_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk_fpga(clk_fpga), .rst(rst), .btn(btn_next), .pulse(nx_p)
    );

    // Synchronize the event switch bank; it is stable long before the pulse arrives
    always_ff @(posedge clk_fpga) begin
        if (rst) begin
            ec_s1 <= 3'd0;
            ec_s2 <= 3'd0;
        end else begin
            ec_s1 <= event_code;
            ec_s2 <= ec_s1;
        end
    end

    // Decode the event and precompute the updated counters and innings-end conditions
    always_comb begin
        legal     = ec_s2 != 3'd7;
        is_wkt    = ec_s2 == 3'd6;
`ifdef CRICKET_EXTRAS_EN
        add       = (ec_s2 == 3'd5) ? 3'd6 : (ec_s2 == 3'd7) ? 3'd1 : (ec_s2 == 3'd6) ? 3'd0 : ec_s2;
        scores    = 1'b1;
`else
        add       = (ec_s2 == 3'd5) ? 3'd6 : (ec_s2 >= 3'd6) ? 3'd0 : ec_s2;
        scores    = legal;
`endif
        apply     = ev_p & scores & (state == INN1 || state == INN2);
        run_sum   = {1'b0, binaryRuns} + {6'd0, add};
        runs_n    = run_sum[8] ? 8'hFF : run_sum[7:0];
        balls_n   = (legal && ball_count != MB) ? ball_count + 8'd1 : ball_count;
        wkts_n    = (is_wkt && wickets != MW) ? wickets + 4'd1 : wickets;
        end_inn   = balls_n == MB || wkts_n == MW;
        chase_won = runs_n > target;
    end

    // Match state register
    always_ff @(posedge clk_fpga) begin
        if (rst) state <= INN1;
        else     state <= state_nx;
    end

    // Next-state: innings end on the causing update, next button advances BREAK and DONE
    always_comb begin
        state_nx = state;
        case (state)
            INN1:    state_nx = (apply && end_inn) ? BREAK : INN1;
            BREAK:   state_nx = nx_p ? INN2 : BREAK;
            INN2:    state_nx = (apply && (chase_won || end_inn)) ? DONE : INN2;
            default: state_nx = nx_p ? INN1 : DONE;
        endcase
    end

    // State-derived flags
    always_comb begin
        inning_over = state == BREAK || state == DONE;
        game_over   = state == DONE;
    end

    // Score counters, target and result, updated alongside the state transition
    always_ff @(posedge clk_fpga) begin
        if (rst || (state == DONE && nx_p)) begin
            binaryRuns <= 8'd0;
            wickets    <= 4'd0;
            ball_count <= 8'd0;
            target     <= 8'd0;
            team       <= 1'b0;
            winner     <= 1'b0;
            tie        <= 1'b0;
        end else if (state == BREAK && nx_p) begin
            binaryRuns <= 8'd0;
            wickets    <= 4'd0;
            ball_count <= 8'd0;
            team       <= 1'b1;
        end else if (apply) begin
            binaryRuns <= runs_n;
            wickets    <= wkts_n;
            ball_count <= balls_n;
            if (state == INN1 && end_inn) target <= runs_n;
            if (state == INN2 && chase_won) winner <= 1'b1;
            else if (state == INN2 && end_inn) tie <= runs_n == target;
        end
    end
endmodule

// File: tb/tb_cricket_score_ctrl.sv
// tb_cricket_score_ctrl: directed and randomized scoring checks against a procedural match model
module tb_cricket_score_ctrl;
    localparam int D  = 4;
    localparam int MB = 6;
    localparam int MW = 2;

    logic       clk_fpga = 1'b0;
    logic       rst = 1'b1;
    logic       btn_event = 1'b0;
    logic       btn_next = 1'b0;
    logic [2:0] event_code = 3'd0;
    logic [7:0] binaryRuns;
    logic [3:0] wickets;
    logic [7:0] ball_count;
    logic [7:0] target;
    logic       team;
    logic       inning_over;
    logic       game_over;
    logic       winner;
    logic       tie;

    int checks = 0;
    int errors = 0;

    // Match model: phase 0 first innings, 1 break, 2 chase, 3 finished
    int m_runs, m_wk, m_balls, m_target, m_team, m_winner, m_tie, m_phase;

    cricket_score_ctrl #(.DEBOUNCE_CYCLES(D), .MAX_BALLS(MB), .MAX_WICKETS(MW)) dut (
        .clk_fpga(clk_fpga), .rst(rst), .btn_event(btn_event), .btn_next(btn_next),
        .event_code(event_code), .binaryRuns(binaryRuns), .wickets(wickets),
        .ball_count(ball_count), .target(target), .team(team), .inning_over(inning_over),
        .game_over(game_over), .winner(winner), .tie(tie)
    );

    always #5 clk_fpga = ~clk_fpga;

    task automatic m_clear();
        m_runs = 0; m_wk = 0; m_balls = 0; m_target = 0;
        m_team = 0; m_winner = 0; m_tie = 0; m_phase = 0;
    endtask

    task automatic m_event(input int c);
        int add;
        bit over;
        if (m_phase == 1 || m_phase == 3) return;
        add = (c == 5) ? 6 : (c >= 1 && c <= 4) ? c : 0;
        if (c == 7) begin
`ifdef CRICKET_EXTRAS_EN
            add = 1;
`else
            return;
`endif
        end
        m_runs = (m_runs + add > 255) ? 255 : m_runs + add;
        if (c != 7 && m_balls < MB) m_balls++;
        if (c == 6 && m_wk < MW) m_wk++;
        over = (m_balls == MB) || (m_wk == MW);
        if (m_phase == 0 && over) begin
            m_target = m_runs;
            m_phase = 1;
        end else if (m_phase == 2 && m_runs > m_target) begin
            m_winner = 1;
            m_phase = 3;
        end else if (m_phase == 2 && over) begin
            m_tie = (m_runs == m_target);
            m_phase = 3;
        end
    endtask

    task automatic m_next();
        if (m_phase == 1) begin
            m_runs = 0; m_wk = 0; m_balls = 0; m_team = 1; m_phase = 2;
        end else if (m_phase == 3) begin
            m_clear();
        end
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".runs"}, int'(binaryRuns), m_runs);
        chk({tag, ".wickets"}, int'(wickets), m_wk);
        chk({tag, ".balls"}, int'(ball_count), m_balls);
        chk({tag, ".target"}, int'(target), m_target);
        chk({tag, ".team"}, int'(team), m_team);
        chk({tag, ".inning_over"}, int'(inning_over), int'(m_phase == 1 || m_phase == 3));
        chk({tag, ".game_over"}, int'(game_over), int'(m_phase == 3));
        chk({tag, ".winner"}, int'(winner), m_winner);
        chk({tag, ".tie"}, int'(tie), m_tie);
    endtask

    task automatic do_reset();
        @(negedge clk_fpga) rst = 1'b1;
        repeat (2) @(negedge clk_fpga);
        rst = 1'b0;
        repeat (3) @(negedge clk_fpga);
        m_clear();
    endtask

    task automatic press(input string tag, input bit nxt, input int code);
        event_code = 3'(code);
        repeat (3) @(negedge clk_fpga);
        if (nxt) btn_next = 1'b1;
        else btn_event = 1'b1;
        repeat (10) @(negedge clk_fpga);
        btn_next = 1'b0;
        btn_event = 1'b0;
        repeat (8) @(negedge clk_fpga);
        if (nxt) m_next();
        else m_event(code);
        check_all(tag);
    endtask

    initial begin
        m_clear();
        repeat (3) @(negedge clk_fpga);
        rst = 1'b0;
        repeat (3) @(negedge clk_fpga);
        check_all("reset");

        event_code = 3'd4;
        repeat (3) @(negedge clk_fpga);
        btn_event = 1'b1;
        repeat (3) @(negedge clk_fpga);
        btn_event = 1'b0;
        repeat (15) @(negedge clk_fpga);
        check_all("glitch");

        btn_event = 1'b1;
        repeat (7) @(posedge clk_fpga);
        #1 chk("latency.early", int'(binaryRuns), 0);
        @(posedge clk_fpga);
        #1 chk("latency.runs", int'(binaryRuns), 4);
        chk("latency.balls", int'(ball_count), 1);
        repeat (3) @(negedge clk_fpga);
        btn_event = 1'b0;
        repeat (10) @(negedge clk_fpga);
        m_event(4);
        check_all("hold");

        do_reset();
        check_all("reset2");
        press("inn1.b1", 0, 5);
        press("inn1.b2", 0, 1);
        press("inn1.b3", 0, 0);
        press("inn1.b4", 0, 6);
        press("inn1.b5", 0, 2);
        press("inn1.b6", 0, 3);
        chk("inn1.target_abs", int'(target), 12);
        press("break.ignore_ev", 0, 4);

        press("chase.next", 1, 0);
        press("chase.w", 0, 6);
        press("chase.6a", 0, 5);
        press("chase.6b", 0, 5);
        press("chase.win", 0, 1);
        chk("chase.winner_abs", int'(winner), 1);
        press("done.ignore_ev", 0, 2);

        press("tie.newmatch", 1, 0);
        press("tie.i1", 0, 5);
        press("tie.i2", 0, 1);
        press("tie.i3", 0, 0);
        press("tie.i4", 0, 6);
        press("tie.i5", 0, 2);
        press("tie.i6", 0, 3);
        press("tie.next", 1, 0);
        press("tie.c1", 0, 5);
        press("tie.c2", 0, 5);
        press("tie.c3", 0, 6);
        press("tie.c4", 0, 6);
        chk("tie.tie_abs", int'(tie), 1);
        press("tie.restart", 1, 0);
        press("inn1.ignore_next", 1, 0);

        press("extras.pre", 0, 2);
        press("extras.wide", 0, 7);

        event_code = 3'd3;
        repeat (3) @(negedge clk_fpga);
        btn_event = 1'b1;
        repeat (4) @(negedge clk_fpga);
        rst = 1'b1;
        @(negedge clk_fpga);
        rst = 1'b0;
        repeat (15) @(negedge clk_fpga);
        btn_event = 1'b0;
        repeat (10) @(negedge clk_fpga);
        m_clear();
        check_all("rst_mid");
        press("after_rst", 0, 3);

        for (int i = 0; i < 160; i++) begin
            if ($urandom_range(0, 5) == 0) press("rand.next", 1, 0);
            else press("rand.ev", 0, int'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
